// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, widths and address checking for the data-memory responder
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  // Returns {in_range, aligned}; limit is the storage size in bytes
  function automatic logic [1:0] addr_check(input logic [63:0] addr, input logic [63:0] limit);
    return {addr < limit, addr[1:0] == 2'b00};
  endfunction
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: DEPTH x 32 storage with byte-enabled synchronous write and registered read
module dmem_byte_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [BE_W-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // Storage is deliberately not reset; only enabled lanes are written
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++)
      if (we && be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready memory responder with programmable wait states and single-cycle response
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
  state_e              state, state_n;
  logic [3:0]          cnt;
  logic                l_we, rsp_ld, accept, enter_resp, c_we, c_err;
  logic [ADDR_W-1:0]   l_addr, c_addr;
  logic [DATA_W-1:0]   l_wdata, c_wdata, mem_rdata;
  logic [BE_W-1:0]     l_be, c_be;
  logic [1:0]          chk;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = req_valid && req_ready;
  // With zero wait states the commit happens on the accept edge itself, so the live request is used
  assign enter_resp = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
  assign c_we = req_ready ? req_we : l_we;
  assign c_addr = req_ready ? req_addr : l_addr;
  assign c_wdata = req_ready ? req_wdata : l_wdata;
  assign c_be = req_ready ? req_be : l_be;
  assign chk = addr_check(64'(c_addr), 64'(4 * DEPTH));
  assign c_err = ~&chk;
  assign rsp_rdata = rsp_ld ? mem_rdata : '0;
  // Next-state selection: commit edge goes to RESP, otherwise accept starts waiting, RESP always retires
  always_comb
    state_n = enter_resp ? RESP : accept ? WAIT : (state == RESP) ? IDLE : state;
  // FSM, wait counter, request latch and registered response flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      l_we      <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      l_be      <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_ld    <= 1'b0;
    end else begin
      state     <= state_n;
      rsp_valid <= enter_resp;
      rsp_err   <= enter_resp & c_err;
      rsp_ld    <= enter_resp & ~c_we & ~c_err;
      if (accept) begin
        cnt     <= 4'(WAIT_CYCLES);
        l_we    <= req_we;
        l_addr  <= req_addr;
        l_wdata <= req_wdata;
        l_be    <= req_be;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  dmem_byte_array #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (enter_resp & c_we & ~c_err),
    .re    (enter_resp & ~c_we & ~c_err),
    .be    (c_be),
    .idx   (c_addr[AW+1:2]),
    .wdata (c_wdata),
    .rdata (mem_rdata)
  );
endmodule
